exception_sequencer: RTL
========================

# exception_sequencer

Multicycle-CPU controller that sequences exception entry, and the sole driver of the `EX_control` select on the PC-source/memory-data mux. When the main control unit flags an invalid-opcode, overflow or divide-by-zero event, this block:
- saves EPC;
- reads the handler address from the fixed vector location in memory;
- steers that memory word into PC.

It also handshakes with the main control unit so the normal fetch stalls until exception entry completes.

## Interface
Parameters:
- `MEM_LATENCY`, default 1: memory read wait cycles after the address is presented (legal 1..7).
- `VEC_OPCODE`, default 253: vector address for an invalid opcode.
- `VEC_OVF`, default 254: vector address for an overflow.
- `VEC_DIV0`, default 255: vector address for a divide-by-zero.

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `opcode_exc` in 1: invalid-opcode event, sampled at the clock edge.
- `ovf_exc` in 1: ALU overflow event.
- `div0_exc` in 1: divide-by-zero event.
- `exc_busy` out 1: sequence in progress; main control must hold off PC and IR writes.
- `exc_done` out 1: one-cycle pulse when exception entry completes.
- `cause` out 2: encoding 00 none, 01 opcode, 10 overflow, 11 div0.
- `exc_addr` out 32: zero-extended vector address for the latched cause.
- `iord_exc` out 1: selects `exc_addr` onto the memory address mux.
- `mem_read` out 1: memory read request.
- `epc_write` out 1: EPC load enable.
- `EX_control` out 1: mux select; 0 = PCSource output, 1 = memory output.
- `pc_write` out 1: PC load enable issued by this block.

## Operation
- States: IDLE, SAVE_EPC, ADDR, WAIT, LOAD_PC, DONE. The state register is reset to IDLE asynchronously.
- IDLE:
  - If any of `opcode_exc`/`ovf_exc`/`div0_exc` is high at a rising edge, latch `cause` and go to SAVE_EPC.
  - Otherwise stay in IDLE.
- Priority on simultaneous events: opcode > overflow > div0. Only the winning cause is latched; the others are dropped.
- SAVE_EPC: `epc_write`=1 for one cycle, then go to ADDR.
- ADDR: `iord_exc`=1 and `mem_read`=1; load the wait counter with `MEM_LATENCY`-1; go to WAIT.
- WAIT:
  - `iord_exc`=1 and `mem_read`=1 held; the counter decrements each cycle.
  - Leave for LOAD_PC on the cycle the counter reads 0.
  - WAIT therefore lasts exactly `MEM_LATENCY` cycles.
- LOAD_PC: `EX_control`=1 and `pc_write`=1 for one cycle; PC captures the memory output at the end of the cycle. Go to DONE.
- DONE: `exc_done`=1 for one cycle, then go to IDLE.
- `exc_busy`=1 in every state except IDLE.
- Event inputs arriving while `exc_busy`=1 are ignored; they are neither queued nor allowed to alter `cause`.
- `cause` and `exc_addr` are sticky: they hold until the next accepted exception or reset. `exc_addr` is a pure decode of `cause`, with cause 00 decoding to 0.
- `EX_control` is 0 in every state other than LOAD_PC.
- All control outputs are decoded from the state register only (Moore); event inputs never reach the outputs combinationally.

## Timing
- Reset values: state IDLE, `cause`=00, `exc_addr`=0, and every 1-bit output 0, including `EX_control`.
- Reset asserted mid-sequence forces IDLE and clears all outputs asynchronously. No partial PC write occurs after reset deasserts.
- Latency from the event-sampling edge:
  - SAVE_EPC occupies cycle 1.
  - ADDR occupies cycle 2.
  - WAIT occupies cycles 3..2+`MEM_LATENCY`.
  - LOAD_PC occupies cycle 3+`MEM_LATENCY`.
  - DONE occupies cycle 4+`MEM_LATENCY`.
- With default parameters, `exc_busy` is high for 5 cycles.
- An event that is high in the DONE cycle is ignored. An event high in the first IDLE cycle after DONE is accepted, so back-to-back sequences have a gap of at least one IDLE cycle.

## Test plan
- Reset: assert `reset` asynchronously between clock edges. All outputs must be 0 immediately and `cause` must be 00; after release, the block must sit idle with no events.
- Single `ovf_exc` pulse, `MEM_LATENCY`=1:
  - `epc_write` high in cycle 1.
  - `iord_exc`/`mem_read` high in cycles 2–3 with `exc_addr`=254.
  - `EX_control`=`pc_write`=1 in cycle 4.
  - `exc_done` high in cycle 5.
  - `cause`=10.
- All three events high on the same edge: `cause`=01 and `exc_addr`=253; the sequence runs once only.
- `div0_exc` pulsed during WAIT of an overflow sequence: `cause` stays 10, no second sequence starts, and `exc_busy` drops after DONE.
- `reset` raised during WAIT: immediate IDLE with no `pc_write` pulse. A later `div0_exc` gives a clean sequence with `exc_addr`=255 and `cause`=11.
- `MEM_LATENCY`=3, `opcode_exc` event: `mem_read` high for exactly 4 cycles (ADDR + 3 WAIT), LOAD_PC in cycle 6, `exc_done` in cycle 7, and `EX_control` high for exactly one cycle.

Source files
------------

// File: rtl/exception_sequencer.sv
// exception_sequencer
//   Sequences exception entry for a multicycle CPU. An accepted event saves
//   EPC, reads the handler address from the fixed vector location, then loads
//   PC with that memory word via the EX_control select. The main control unit
//   stalls on exc_busy until the sequence completes.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   opcode_exc  in   invalid-opcode event
//   ovf_exc     in   ALU overflow event
//   div0_exc    in   divide-by-zero event
//   exc_busy    out  sequence in progress (hold off PC/IR writes)
//   exc_done    out  one-cycle pulse on completion
//   cause       out  00 none, 01 opcode, 10 overflow, 11 div0 (sticky)
//   exc_addr    out  zero-extended vector address decoded from cause
//   iord_exc    out  selects exc_addr onto the memory address mux
//   mem_read    out  memory read request
//   epc_write   out  EPC load enable
//   EX_control  out  PC mux select: 0 = PCSource, 1 = memory output
//   pc_write    out  PC load enable
module exception_sequencer #(
  parameter int MEM_LATENCY = 1,
  parameter int VEC_OPCODE  = 253,
  parameter int VEC_OVF     = 254,
  parameter int VEC_DIV0    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        opcode_exc,
  input  logic        ovf_exc,
  input  logic        div0_exc,
  output logic        exc_busy,
  output logic        exc_done,
  output logic [1:0]  cause,
  output logic [31:0] exc_addr,
  output logic        iord_exc,
  output logic        mem_read,
  output logic        epc_write,
  output logic        EX_control,
  output logic        pc_write
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE_EPC,
    S_ADDR,
    S_WAIT,
    S_LOAD_PC,
    S_DONE
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next-state, wait counter and cause capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE: begin
        // Fixed priority: opcode > overflow > div0; losers are dropped.
        if (opcode_exc) begin
          cause_d = 2'b01;
          state_d = S_SAVE_EPC;
        end else if (ovf_exc) begin
          cause_d = 2'b10;
          state_d = S_SAVE_EPC;
        end else if (div0_exc) begin
          cause_d = 2'b11;
          state_d = S_SAVE_EPC;
        end
      end
      S_SAVE_EPC: state_d = S_ADDR;
      S_ADDR: begin
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Counter starts at MEM_LATENCY-1, so WAIT spans MEM_LATENCY cycles.
        if (cnt_q == 3'd0) begin
          state_d = S_LOAD_PC;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_LOAD_PC: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore outputs: decoded from the state register only.
  always_comb begin
    exc_busy   = 1'b1;
    exc_done   = 1'b0;
    iord_exc   = 1'b0;
    mem_read   = 1'b0;
    epc_write  = 1'b0;
    EX_control = 1'b0;
    pc_write   = 1'b0;
    unique case (state_q)
      S_IDLE:     exc_busy = 1'b0;
      S_SAVE_EPC: epc_write = 1'b1;
      S_ADDR, S_WAIT: begin
        iord_exc = 1'b1;
        mem_read = 1'b1;
      end
      S_LOAD_PC: begin
        EX_control = 1'b1;
        pc_write   = 1'b1;
      end
      S_DONE:  exc_done = 1'b1;
      default: exc_busy = 1'b0;
    endcase
  end

  // Vector address is a pure decode of the sticky cause register.
  always_comb begin
    exc_addr = 32'd0;
    unique case (cause_q)
      2'b01:   exc_addr = 32'(VEC_OPCODE);
      2'b10:   exc_addr = 32'(VEC_OVF);
      2'b11:   exc_addr = 32'(VEC_DIV0);
      default: exc_addr = 32'd0;
    endcase
  end

  assign cause = cause_q;

endmodule
